// File: rtl/regfile_wb_queue.sv
// Writeback queue for the 32x32b 1R1W register file.
// Buffers writeback requests in an in-order FIFO, drains one entry per cycle
// onto the register file write port, and offers a forwarding lookup so readers
// see values that are still pending in the queue.
module regfile_wb_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_val,
    output logic                     req_rdy,
    input  logic [AW-1:0]            req_addr,
    input  logic [DW-1:0]            req_data,
    input  logic                     rf_hold,
    output logic                     rf_wen,
    output logic [AW-1:0]            rf_waddr,
    output logic [DW-1:0]            rf_wdata,
    input  logic [AW-1:0]            lk_addr,
    output logic                     lk_hit,
    output logic [DW-1:0]            lk_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             enq;
    logic             deq;
    logic [PW-1:0]    lk_idx;

    assign req_rdy  = (count_q != FULL);
    // Writes to x0 complete the handshake but are never stored.
    assign enq      = req_val && req_rdy && (req_addr != '0);
    assign deq      = (count_q != '0) && !rf_hold;
    assign rf_wen   = deq;
    assign rf_waddr = (count_q != '0) ? addr_q[head_q] : '0;
    assign rf_wdata = (count_q != '0) ? data_q[head_q] : '0;
    assign count    = count_q;

    // Next-state for pointers, occupancy and valid bits.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        vld_d   = vld_q;
        if (enq) begin
            vld_d[tail_q] = 1'b1;
            tail_d        = tail_q + PW'(1);
        end
        if (deq) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + PW'(1);
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; reset discards every pending entry at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            vld_q   <= vld_d;
        end
    end

    // Entry payload storage; qualified by the valid bits, so no reset needed.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail_q] <= req_addr;
            data_q[tail_q] <= req_data;
        end
    end

    // Forwarding lookup: walk oldest to youngest from head so the last match
    // (youngest, closest to tail) wins, which stays correct across wrap.
    always_comb begin
        lk_hit  = 1'b0;
        lk_data = '0;
        lk_idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            lk_idx = head_q + PW'(i);
            if ((lk_addr != '0) && vld_q[lk_idx] && (addr_q[lk_idx] == lk_addr)) begin
                lk_hit  = 1'b1;
                lk_data = data_q[lk_idx];
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue with immediate-assertion checks.
module tb_regfile_wb_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_val;
    logic        req_rdy;
    logic [4:0]  req_addr;
    logic [31:0] req_data;
    logic        rf_hold;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  lk_addr;
    logic        lk_hit;
    logic [31:0] lk_data;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    regfile_wb_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .req_addr (req_addr),
        .req_data (req_data),
        .rf_hold  (rf_hold),
        .rf_wen   (rf_wen),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .lk_addr  (lk_addr),
        .lk_hit   (lk_hit),
        .lk_data  (lk_data),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_rdy"},   64'(req_rdy),  64'd1);
        chk({tag, "_wen"},   64'(rf_wen),   64'd0);
        chk({tag, "_waddr"}, 64'(rf_waddr), 64'd0);
        chk({tag, "_wdata"}, 64'(rf_wdata), 64'd0);
        chk({tag, "_cnt"},   64'(count),    64'd0);
        chk({tag, "_hit"},   64'(lk_hit),   64'd0);
        chk({tag, "_lkd"},   64'(lk_data),  64'd0);
    endtask

    initial begin
        // Reset with a request held valid
        rst = 1'b1; req_val = 1'b1; req_addr = 5'd7; req_data = 32'h1234;
        rf_hold = 1'b0; lk_addr = 5'd7;
        step(); step();
        idle_chk("rst");
        @(negedge clk);
        rst = 1'b0;
        req_val = 1'b1; req_addr = 5'd3; req_data = 32'hDEADBEEF; lk_addr = 5'd3;
        #1;
        chk("t1_same_cycle_hit", 64'(lk_hit), 64'd0);
        step();
        req_val = 1'b0; #1;
        chk("t1_wen",   64'(rf_wen),   64'd1);
        chk("t1_waddr", 64'(rf_waddr), 64'd3);
        chk("t1_wdata", 64'(rf_wdata), 64'hDEADBEEF);
        chk("t1_hit",   64'(lk_hit),   64'd1);
        chk("t1_lkd",   64'(lk_data),  64'hDEADBEEF);
        chk("t1_cnt",   64'(count),    64'd1);
        step();
        chk("t1_cnt_after", 64'(count),  64'd0);
        chk("t1_hit_after", 64'(lk_hit), 64'd0);
        chk("t1_wen_after", 64'(rf_wen), 64'd0);

        // Fill under hold, full blocks requests, no bypass-on-full
        rf_hold = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            req_val = 1'b1; req_addr = 5'(k); req_data = 32'(k * 'h11);
            step();
        end
        req_addr = 5'd9; req_data = 32'h99; #1;
        chk("t2_cnt_full", 64'(count),   64'd4);
        chk("t2_rdy_full", 64'(req_rdy), 64'd0);
        chk("t2_wen_hold", 64'(rf_wen),  64'd0);
        step();
        chk("t2_cnt_5th", 64'(count), 64'd4);
        lk_addr = 5'd9; #1;
        chk("t2_no_9", 64'(lk_hit), 64'd0);
        rf_hold = 1'b0; #1;
        chk("t2_rdy_drain", 64'(req_rdy), 64'd0);
        for (int k = 1; k <= 4; k++) begin
            chk("t2_wen",   64'(rf_wen),   64'd1);
            chk("t2_waddr", 64'(rf_waddr), 64'(k));
            chk("t2_wdata", 64'(rf_wdata), 64'(k * 'h11));
            step();
            req_val = 1'b0; #1;
            if (k == 1) chk("t2_cnt_nobypass", 64'(count), 64'd3);
        end
        chk("t2_cnt_end", 64'(count),  64'd0);
        chk("t2_wen_end", 64'(rf_wen), 64'd0);

        // Request to x0 is accepted but dropped
        req_val = 1'b1; req_addr = 5'd0; req_data = 32'hFFFFFFFF; lk_addr = 5'd0; #1;
        chk("t4_rdy", 64'(req_rdy), 64'd1);
        step();
        req_val = 1'b0; #1;
        chk("t4_cnt", 64'(count),  64'd0);
        chk("t4_wen", 64'(rf_wen), 64'd0);
        chk("t4_hit", 64'(lk_hit), 64'd0);

        // Steady stream across pointer wrap
        for (int k = 1; k <= 10; k++) begin
            req_val = 1'b1; req_addr = 5'(k); req_data = 32'(k * 'h100); #1;
            if (k > 1) begin
                chk("t5_wen",   64'(rf_wen),   64'd1);
                chk("t5_waddr", 64'(rf_waddr), 64'(k - 1));
                chk("t5_wdata", 64'(rf_wdata), 64'((k - 1) * 'h100));
            end
            step();
            chk("t5_cnt", 64'(count), 64'd1);
        end
        req_val = 1'b0; #1;
        chk("t5_last_waddr", 64'(rf_waddr), 64'd10);
        chk("t5_last_wdata", 64'(rf_wdata), 64'hA00);
        step();
        chk("t5_cnt_end", 64'(count), 64'd0);

        // Youngest-match forwarding; these two entries straddle the wrap
        rf_hold = 1'b1; lk_addr = 5'd5;
        req_val = 1'b1; req_addr = 5'd5; req_data = 32'hA;
        step();
        req_data = 32'hB; #1;
        chk("t3_one_lkd", 64'(lk_data), 64'hA);
        step();
        req_val = 1'b0; #1;
        chk("t3_hit", 64'(lk_hit),  64'd1);
        chk("t3_lkd", 64'(lk_data), 64'hB);
        chk("t3_cnt", 64'(count),   64'd2);
        lk_addr = 5'd6; #1;
        chk("t3_miss_hit", 64'(lk_hit),  64'd0);
        chk("t3_miss_lkd", 64'(lk_data), 64'd0);
        lk_addr = 5'd5; rf_hold = 1'b0; #1;
        chk("t3_w0_addr", 64'(rf_waddr), 64'd5);
        chk("t3_w0_data", 64'(rf_wdata), 64'hA);
        chk("t3_head_hit", 64'(lk_hit),  64'd1);
        step();
        chk("t3_w1_data", 64'(rf_wdata), 64'hB);
        chk("t3_w1_wen",  64'(rf_wen),   64'd1);
        step();
        chk("t3_cnt_end", 64'(count),  64'd0);
        chk("t3_hit_end", 64'(lk_hit), 64'd0);

        // Asynchronous reset in the middle of a cycle with 3 pending
        rf_hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_val = 1'b1; req_addr = 5'(8 + k); req_data = 32'(k + 'h50);
            step();
        end
        req_val = 1'b0; lk_addr = 5'd8; rf_hold = 1'b0; #1;
        chk("t6_cnt_pre", 64'(count),  64'd3);
        chk("t6_wen_pre", 64'(rf_wen), 64'd1);
        #1 rst = 1'b1;
        #1;
        idle_chk("t6_rst");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t6_post_wen", 64'(rf_wen), 64'd0);
            chk("t6_post_cnt", 64'(count),  64'd0);
            chk("t6_post_hit", 64'(lk_hit), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
